// File: rtl/find_top_bottom.sv
// rtl/find_top_bottom.sv - row-mapping stage: scans downward from the first star pixel to find the star's top and bottom rows
module find_top_bottom #(
    parameter int xSz       = 3,
    parameter int ySz       = 3,
    parameter int addrSz    = 6,
    parameter int colSz     = 3,
    parameter int MAX_X     = 6,
    parameter int MAX_Y     = 6,
    parameter int THRESHOLD = 0,
    parameter int HALF_W    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              goMapRows,
    input  logic [xSz-1:0]    xStart,
    input  logic [ySz-1:0]    yStart,
    output logic              rdEn,
    output logic [addrSz-1:0] rdAddress,
    input  logic [colSz-1:0]  rdData,
    output logic [ySz-1:0]    yTop,
    output logic [ySz-1:0]    yBottom,
    output logic              topBottomFound,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;

    localparam int XW = xSz + 1;
    localparam logic [31:0] MAX_X_BITS = MAX_X;

    state_t           state_q, state_d;
    logic [ySz-1:0]   row_q, row_d;
    logic [xSz-1:0]   col_q, col_d;
    logic [xSz-1:0]   xlo_q, xlo_d;
    logic [xSz-1:0]   xhi_q, xhi_d;
    logic [ySz-1:0]   ystart_q, ystart_d;
    logic [ySz-1:0]   ybot_q, ybot_d;
    logic [ySz-1:0]   ytop_out_q, ytop_out_d;
    logic [ySz-1:0]   ybot_out_q, ybot_out_d;
    logic             found_q, found_d;
    logic             busy_q, busy_d;
    logic             rden_q, rden_d;

    logic [XW-1:0]    x_ext;
    logic [XW-1:0]    lo_ext;
    logic [XW-1:0]    hi_ext;
    logic             lit;
    logic [addrSz-1:0] addr_acc;

    // Next-state, window latch and result capture for the row scan
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        xlo_d      = xlo_q;
        xhi_d      = xhi_q;
        ystart_d   = ystart_q;
        ybot_d     = ybot_q;
        ytop_out_d = ytop_out_q;
        ybot_out_d = ybot_out_q;

        // Window bounds carry one extra bit so xStart-HALF_W cannot wrap
        x_ext  = {1'b0, xStart};
        lo_ext = (x_ext >= XW'(HALF_W)) ? x_ext - XW'(HALF_W) : '0;
        hi_ext = x_ext + XW'(HALF_W);
        if (hi_ext > XW'(MAX_X - 1)) begin
            hi_ext = XW'(MAX_X - 1);
        end

        lit = (rdData > colSz'(THRESHOLD));

        case (state_q)
            IDLE: begin
                if (goMapRows) begin
                    ystart_d = yStart;
                    row_d    = yStart;
                    col_d    = lo_ext[xSz-1:0];
                    xlo_d    = lo_ext[xSz-1:0];
                    xhi_d    = hi_ext[xSz-1:0];
                    // A stale (dark) start row still reports yBottom = yStart
                    ybot_d   = yStart;
                    if ({1'b0, yStart} >= (ySz + 1)'(MAX_Y)) begin
                        ytop_out_d = yStart;
                        ybot_out_d = yStart;
                        state_d    = DONE;
                    end else begin
                        state_d    = READ;
                    end
                end
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (lit) begin
                    ybot_d = row_q;
                    if (row_q == ySz'(MAX_Y - 1)) begin
                        ytop_out_d = ystart_q;
                        ybot_out_d = row_q;
                        state_d    = DONE;
                    end else begin
                        row_d   = row_q + ySz'(1);
                        col_d   = xlo_q;
                        state_d = READ;
                    end
                end else if (col_q < xhi_q) begin
                    col_d   = col_q + xSz'(1);
                    state_d = READ;
                end else begin
                    ytop_out_d = ystart_q;
                    ybot_out_d = ybot_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rden_d  = (state_d == READ) || (state_d == CHECK);
        busy_d  = (state_d != IDLE);
        found_d = (state_d == DONE);
    end

    // Row*MAX_X as a sum of shifted rows, one term per set bit of MAX_X
    always_comb begin
        addr_acc = addrSz'(col_q);
        for (int i = 0; i < addrSz; i++) begin
            if (MAX_X_BITS[i]) begin
                addr_acc = addr_acc + (addrSz'(row_q) << i);
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            xlo_q      <= '0;
            xhi_q      <= '0;
            ystart_q   <= '0;
            ybot_q     <= '0;
            ytop_out_q <= '0;
            ybot_out_q <= '0;
            found_q    <= 1'b0;
            busy_q     <= 1'b0;
            rden_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            xlo_q      <= xlo_d;
            xhi_q      <= xhi_d;
            ystart_q   <= ystart_d;
            ybot_q     <= ybot_d;
            ytop_out_q <= ytop_out_d;
            ybot_out_q <= ybot_out_d;
            found_q    <= found_d;
            busy_q     <= busy_d;
            rden_q     <= rden_d;
        end
    end

    assign rdEn           = rden_q;
    assign rdAddress      = rden_q ? addr_acc : '0;
    assign yTop           = ytop_out_q;
    assign yBottom        = ybot_out_q;
    assign topBottomFound = found_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_find_top_bottom.sv
// tb/tb_find_top_bottom.sv - scoreboard bench for find_top_bottom
module tb_find_top_bottom;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       go0 = 1'b0, go1 = 1'b0;
    logic [2:0] xs0 = '0, xs1 = '0;
    logic [2:0] ys0 = '0, ys1 = '0;
    logic       rden0, rden1;
    logic [5:0] addr0, addr1;
    logic [2:0] rdata0 = '0, rdata1 = '0;
    logic [2:0] ytop0, ytop1, ybot0, ybot1;
    logic       found0, found1, busy0, busy1;

    logic [2:0] mem0 [64];
    logic [2:0] mem1 [64];

    typedef struct {
        int ytop;
        int ybot;
        int lat;
        int go_cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   log0[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic       prev_rden0 = 1'b0;
    logic [5:0] prev_addr0 = '0;

    find_top_bottom #(.THRESHOLD(0)) u_dut (
        .clk(clk), .reset(reset), .goMapRows(go0), .xStart(xs0), .yStart(ys0),
        .rdEn(rden0), .rdAddress(addr0), .rdData(rdata0), .yTop(ytop0),
        .yBottom(ybot0), .topBottomFound(found0), .busy(busy0)
    );

    find_top_bottom #(.THRESHOLD(3)) u_thr (
        .clk(clk), .reset(reset), .goMapRows(go1), .xStart(xs1), .yStart(ys1),
        .rdEn(rden1), .rdAddress(addr1), .rdData(rdata1), .yTop(ytop1),
        .yBottom(ybot1), .topBottomFound(found1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rdata0 <= mem0[addr0];
        rdata1 <= mem1[addr1];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_log(input string name, input int exp[$]);
        chk({name, "_len"}, log0.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log0.size(); i++) begin
            chk($sformatf("%s_addr%0d", name, i), log0[i], exp[i]);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
    endtask

    // Called at posedge+#1; returns one cycle later at posedge+#1
    task automatic go(input int sel, input int x, input int y,
                      input int et, input int eb, input int lat, input bit push);
        exp_t e;
        e.ytop = et; e.ybot = eb; e.lat = lat; e.go_cyc = cyc;
        if (sel == 0) begin
            xs0 = 3'(x); ys0 = 3'(y); go0 = 1'b1;
            if (push) sb0.push_back(e);
        end else begin
            xs1 = 3'(x); ys1 = 3'(y); go1 = 1'b1;
            if (push) sb1.push_back(e);
        end
        @(posedge clk); #1;
        go0 = 1'b0;
        go1 = 1'b0;
    endtask

    task automatic wait_done(input int sel, input string name);
        int n;
        n = 0;
        while (n < 60 && ((sel == 0) ? sb0.size() : sb1.size()) > 0) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, (sel == 0) ? sb0.size() : sb1.size(), 0);
        sb0.delete();
        sb1.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected results when a done pulse appears and logs addresses
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (!rden0) chk("addr_zero_when_idle", addr0, 0);
            if (rden0 && (!prev_rden0 || addr0 != prev_addr0)) log0.push_back(int'(addr0));
            if (found0) begin
                if (sb0.size() == 0) begin
                    chk("unexpected_done0", 1, 0);
                end else begin
                    e = sb0.pop_front();
                    chk("ytop0", ytop0, e.ytop);
                    chk("ybot0", ybot0, e.ybot);
                    chk("latency0", cyc - e.go_cyc, e.lat);
                    chk("busy_at_done0", busy0, 1);
                end
            end
            if (found1) begin
                if (sb1.size() == 0) begin
                    chk("unexpected_done1", 1, 0);
                end else begin
                    e = sb1.pop_front();
                    chk("ytop1", ytop1, e.ytop);
                    chk("ybot1", ybot1, e.ybot);
                    chk("latency1", cyc - e.go_cyc, e.lat);
                end
            end
        end
        prev_rden0 = rden0;
        prev_addr0 = addr0;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=1 required=0");
        $fatal(1, "global timeout");
    end

    initial begin
        int q[$];
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rden", rden0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ytop", ytop0, 0);
        chk("rst_ybot", ybot0, 0);
        chk("rst_found", found0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Column star
        mem0[8] = 3'd1; mem0[14] = 3'd1; mem0[20] = 3'd1;
        log0.delete();
        go(0, 2, 1, 1, 3, 19, 1'b1);
        chk("busy_after_go", busy0, 1);
        wait_done(0, "column");
        q = '{7, 8, 13, 14, 19, 20, 25, 26, 27};
        chk_log("column", q);

        // Left-edge clamp
        clear_mem();
        mem0[0] = 3'd1; mem0[7] = 3'd1;
        log0.delete();
        go(0, 0, 0, 0, 1, 11, 1'b1);
        wait_done(0, "leftedge");
        q = '{0, 6, 7, 12, 13};
        chk_log("leftedge", q);

        // Bottom wrap
        clear_mem();
        for (int r = 0; r < 6; r++) mem0[r * 6 + 5] = 3'd1;
        log0.delete();
        go(0, 5, 3, 3, 5, 13, 1'b1);
        wait_done(0, "bottom");
        q = '{22, 23, 28, 29, 34, 35};
        chk_log("bottom", q);

        // Second go while busy is ignored
        clear_mem();
        mem0[8] = 3'd1; mem0[14] = 3'd1; mem0[20] = 3'd1;
        mem0[23] = 3'd1; mem0[29] = 3'd1; mem0[35] = 3'd1;
        go(0, 2, 1, 1, 3, 19, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        go(0, 5, 3, 0, 0, 0, 1'b0);
        wait_done(0, "go_ignored");
        repeat (25) @(posedge clk);
        #1;

        // Start row outside the image
        log0.delete();
        go(0, 3, 6, 6, 6, 1, 1'b1);
        wait_done(0, "ystart_oob");
        chk("ystart_oob_noreads", log0.size(), 0);

        // Reset during CHECK aborts without a done pulse
        go(0, 2, 1, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rden", rden0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_ytop", ytop0, 0);
        chk("abort_ybot", ybot0, 0);
        chk("abort_found", found0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        // Threshold: value 3 is not above THRESHOLD=3
        clear_mem();
        mem1[8] = 3'd4; mem1[14] = 3'd3;
        go(1, 2, 1, 1, 1, 11, 1'b1);
        wait_done(1, "threshold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
